ov7670_dvp_source: RTL and testbench

Synthesizable OV7670 camera emulator that drives the camera's parallel DVP output interface: PCLK, VSYNC, HREF and D[7:0], with OV7670 VGA RGB565 frame timing. It produces deterministic test patterns. It sits in place of the physical sensor pins in front of `ov7670_capture`. Its uses are bring-up without a camera, closed-loop simulation of the capture → core → lenet path, and on-board self-test selected by a switch.

---
 rtl/ov7670_emu_pkg.sv | 19 +
 rtl/ov7670_pattern_gen.sv | 24 ++
 rtl/ov7670_dvp_source.sv | 165 ++++++++++++++++
 tb/tb_ov7670_dvp_source.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_emu_pkg.sv
// Shared types and constants for the OV7670 DVP camera emulator.
package ov7670_emu_pkg;

    typedef enum logic [1:0] {
        RAMP_H = 2'd0,
        RAMP_V = 2'd1,
        BARS   = 2'd2,
        FIXED  = 2'd3
    } pattern_e;

    typedef logic [15:0] rgb565_t;

    // Classic 8-bar order: white, yellow, cyan, green, magenta, red, blue, black.
    localparam rgb565_t BAR_COLORS [8] = '{
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
        16'hF81F, 16'hF800, 16'h001F, 16'h0000
    };

endpackage

// File: rtl/ov7670_pattern_gen.sv
// Combinational RGB565 test-pattern selector for the DVP emulator.
module ov7670_pattern_gen
    import ov7670_emu_pkg::*;
(
    input  logic [15:0] x_i,
    input  logic [15:0] y_i,
    input  logic [2:0]  bar_i,
    input  pattern_e    mode_i,
    input  rgb565_t     fixed_i,
    output rgb565_t     pixel_o
);

    always_comb begin
        pixel_o = '0;
        case (mode_i)
            RAMP_H:  pixel_o = x_i;
            RAMP_V:  pixel_o = y_i;
            BARS:    pixel_o = BAR_COLORS[bar_i];
            FIXED:   pixel_o = fixed_i;
            default: pixel_o = '0;
        endcase
    end

endmodule

// File: rtl/ov7670_dvp_source.sv
// OV7670 DVP output emulator: PCLK/VSYNC/HREF/D frame timing with test patterns.
module ov7670_dvp_source
    import ov7670_emu_pkg::*;
#(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int HBLANK       = 288,
    parameter int VSYNC_LINES  = 3,
    parameter int VBACK_LINES  = 17,
    parameter int VFRONT_LINES = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [15:0] fixed_pixel,
    output logic        pclk,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  d,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        busy
);

    localparam int LINE_LEN  = 2 * WIDTH + HBLANK;
    localparam int FRAME_LEN = VSYNC_LINES + VBACK_LINES + HEIGHT + VFRONT_LINES;

    localparam logic [15:0] H_LAST      = 16'(LINE_LEN - 1);
    localparam logic [15:0] V_LAST      = 16'(FRAME_LEN - 1);
    localparam logic [15:0] H_ACTIVE    = 16'(2 * WIDTH);
    localparam logic [15:0] V_SYNC_END  = 16'(VSYNC_LINES);
    localparam logic [15:0] V_ACT_START = 16'(VSYNC_LINES + VBACK_LINES);
    localparam logic [15:0] V_ACT_END   = 16'(VSYNC_LINES + VBACK_LINES + HEIGHT);
    localparam logic [15:0] BAR_LAST    = 16'(WIDTH / 8 - 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e      state_q, state_d;
    logic        ph_q;
    logic [15:0] hcnt_q, hcnt_d;
    logic [15:0] vcnt_q, vcnt_d;
    logic [2:0]  bar_q, bar_d;
    logic [15:0] bar_px_q, bar_px_d;
    pattern_e    mode_q, mode_d;
    rgb565_t     fixed_q, fixed_d;
    logic        vsync_q, href_q, frame_done_q;
    logic [7:0]  d_q;
    logic [15:0] frame_cnt_q;

    logic        start;
    logic        run_d, done_d, vsync_d, href_d;
    logic [7:0]  d_d;
    logic [15:0] pix_x, pix_y;
    rgb565_t     pixel;

    // Next raster position for the coming falling slot; outputs are registered from it.
    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        vcnt_d   = vcnt_q;
        bar_d    = bar_q;
        bar_px_d = bar_px_q;
        mode_d   = mode_q;
        fixed_d  = fixed_q;
        start    = 1'b0;
        if (state_q == IDLE) begin
            start = enable;
        end else if (hcnt_q == H_LAST && vcnt_q == V_LAST) begin
            start = enable;
            if (!enable) begin
                state_d = IDLE;
            end
        end else if (hcnt_q == H_LAST) begin
            hcnt_d   = '0;
            vcnt_d   = vcnt_q + 16'd1;
            bar_d    = '0;
            bar_px_d = '0;
        end else begin
            hcnt_d = hcnt_q + 16'd1;
            // Bar index steps every WIDTH/8 pixels, i.e. on the low-byte to high-byte transition.
            if (hcnt_q[0]) begin
                if (bar_px_q == BAR_LAST) begin
                    bar_px_d = '0;
                    bar_d    = bar_q + 3'd1;
                end else begin
                    bar_px_d = bar_px_q + 16'd1;
                end
            end
        end
        if (start) begin
            state_d  = RUN;
            hcnt_d   = '0;
            vcnt_d   = '0;
            bar_d    = '0;
            bar_px_d = '0;
            mode_d   = pattern_e'(mode);
            fixed_d  = fixed_pixel;
        end
    end

    assign run_d   = (state_d == RUN);
    assign done_d  = run_d && !start && (hcnt_d == H_LAST) && (vcnt_d == V_LAST);
    assign vsync_d = run_d && (vcnt_d < V_SYNC_END);
    assign href_d  = run_d && (vcnt_d >= V_ACT_START) && (vcnt_d < V_ACT_END) && (hcnt_d < H_ACTIVE);
    assign pix_x   = {1'b0, hcnt_d[15:1]};
    assign pix_y   = vcnt_d - V_ACT_START;
    assign d_d     = !href_d ? 8'h00 : (hcnt_d[0] ? pixel[7:0] : pixel[15:8]);

    ov7670_pattern_gen u_pattern_gen (
        .x_i     (pix_x),
        .y_i     (pix_y),
        .bar_i   (bar_d),
        .mode_i  (mode_d),
        .fixed_i (fixed_d),
        .pixel_o (pixel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ph_q         <= 1'b0;
            hcnt_q       <= '0;
            vcnt_q       <= '0;
            bar_q        <= '0;
            bar_px_q     <= '0;
            mode_q       <= RAMP_H;
            fixed_q      <= '0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            d_q          <= '0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            ph_q         <= ~ph_q;
            frame_done_q <= 1'b0;
            // ph_q high means this edge is the pclk falling edge.
            if (ph_q) begin
                state_q      <= state_d;
                hcnt_q       <= hcnt_d;
                vcnt_q       <= vcnt_d;
                bar_q        <= bar_d;
                bar_px_q     <= bar_px_d;
                mode_q       <= mode_d;
                fixed_q      <= fixed_d;
                vsync_q      <= vsync_d;
                href_q       <= href_d;
                d_q          <= d_d;
                frame_done_q <= done_d;
                if (done_d) begin
                    frame_cnt_q <= frame_cnt_q + 16'd1;
                end
            end
        end
    end

    assign pclk       = ph_q;
    assign vsync      = vsync_q;
    assign href       = href_q;
    assign d          = d_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign busy       = (state_q == RUN);

endmodule

// File: tb/tb_ov7670_dvp_source.sv
// Self-checking bench for ov7670_dvp_source against a slot-index frame model.
module tb_ov7670_dvp_source;

    localparam int W  = 8;
    localparam int H  = 2;
    localparam int HB = 4;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int VF = 1;
    localparam int L  = 2 * W + HB;
    localparam int F  = VS + VB + H + VF;
    localparam int FS = L * F;

    localparam logic [15:0] BARS_REF [8] = '{
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
        16'hF81F, 16'hF800, 16'h001F, 16'h0000
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] fixed_pixel = 16'h0000;
    logic        pclk, vsync, href, frame_done, busy;
    logic [7:0]  d;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    ov7670_dvp_source #(
        .WIDTH(W), .HEIGHT(H), .HBLANK(HB),
        .VSYNC_LINES(VS), .VBACK_LINES(VB), .VFRONT_LINES(VF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .fixed_pixel(fixed_pixel), .pclk(pclk), .vsync(vsync), .href(href),
        .d(d), .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: a frame is FS consecutive falling slots indexed by m_k.
    logic        m_ph, m_run, m_done;
    int          m_k;
    logic [1:0]  m_mode;
    logic [15:0] m_fixed, m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph <= 1'b0; m_run <= 1'b0; m_done <= 1'b0; m_k <= 0;
            m_mode <= 2'd0; m_fixed <= 16'h0; m_cnt <= 16'h0;
        end else begin
            m_ph   <= ~m_ph;
            m_done <= 1'b0;
            if (m_ph) begin
                if (!m_run || m_k == FS - 1) begin
                    m_run <= enable;
                    m_k   <= 0;
                    if (enable) begin
                        m_mode  <= mode;
                        m_fixed <= fixed_pixel;
                    end
                end else begin
                    m_k <= m_k + 1;
                    if (m_k + 1 == FS - 1) begin
                        m_done <= 1'b1;
                        m_cnt  <= m_cnt + 16'd1;
                    end
                end
            end
        end
    end

    function automatic logic e_vsync();
        return m_run && ((m_k / L) < VS);
    endfunction

    function automatic logic e_href();
        int line;
        int col;
        line = m_k / L;
        col  = m_k % L;
        return m_run && (line >= VS + VB) && (line < VS + VB + H) && (col < 2 * W);
    endfunction

    function automatic logic [7:0] e_d();
        int col;
        int x;
        int y;
        logic [15:0] p;
        col = m_k % L;
        x   = col / 2;
        y   = m_k / L - (VS + VB);
        if (!e_href()) return 8'h00;
        case (m_mode)
            2'd0:    p = 16'(x);
            2'd1:    p = 16'(y);
            2'd2:    p = BARS_REF[x / (W / 8)];
            default: p = m_fixed;
        endcase
        return (col % 2 == 0) ? p[15:8] : p[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        repeat (3) tick();
        checks++; if (pclk !== 1'b0) begin errors++; $display("FAIL reset_pclk: got %b expected 0", pclk); end
        checks++; if (vsync !== 1'b0) begin errors++; $display("FAIL reset_vsync: got %b expected 0", vsync); end
        checks++; if (href !== 1'b0) begin errors++; $display("FAIL reset_href: got %b expected 0", href); end
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_d: got %h expected 00", d); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (frame_cnt !== 16'h0) begin errors++; $display("FAIL reset_frame_cnt: got %h expected 0000", frame_cnt); end
        rst_n = 1'b1;
        repeat (4) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy got %b expected 0", busy); end
        $display("test_reset done");
    endtask

    task automatic test_ramp_frame();
        int t, lat, want_lat, vs_cnt, href_cnt, t_first;
        logic [7:0] bytes[$];
        logic [12:0] got, exp;
        logic [7:0] eb;
        mode = 2'd0;
        fixed_pixel = 16'($urandom);
        repeat ($urandom_range(0, 3)) tick();
        want_lat = m_ph ? 1 : 2;
        enable = 1'b1;
        lat = 0;
        while (!vsync && lat < 4) begin tick(); lat++; end
        checks++; if (lat != want_lat) begin errors++; $display("FAIL start_latency: got %0d clk expected %0d", lat, want_lat); end
        t = 0; vs_cnt = 0; href_cnt = 0; t_first = -1;
        while (busy && t < 2 * FS + 20) begin
            got = {pclk, vsync, href, busy, frame_done, d};
            exp = {m_ph, e_vsync(), e_href(), m_run, m_done, e_d()};
            checks++; if (got !== exp) begin errors++; $display("FAIL ramp_cycle t=%0d: got %h expected %h", t, got, exp); end
            if (vsync) vs_cnt++;
            if (href) begin
                href_cnt++;
                if (t_first < 0) t_first = t;
                if (pclk) bytes.push_back(d);
            end
            if (t == 10) enable = 1'b0;
            tick(); t++;
        end
        checks++; if (t != 2 * FS) begin errors++; $display("FAIL ramp_frame_len: got %0d clk expected %0d", t, 2 * FS); end
        checks++; if (vs_cnt != 2 * L * VS) begin errors++; $display("FAIL ramp_vsync_len: got %0d expected %0d", vs_cnt, 2 * L * VS); end
        checks++; if (t_first != 2 * L * (VS + VB)) begin errors++; $display("FAIL ramp_first_href: got %0d expected %0d", t_first, 2 * L * (VS + VB)); end
        checks++; if (href_cnt != 2 * 2 * W * H) begin errors++; $display("FAIL ramp_href_len: got %0d expected %0d", href_cnt, 2 * 2 * W * H); end
        checks++; if (bytes.size() != 2 * W * H) begin errors++; $display("FAIL ramp_byte_count: got %0d expected %0d", bytes.size(), 2 * W * H); end
        for (int i = 0; i < bytes.size() && i < 2 * W * H; i++) begin
            eb = ((i % (2 * W)) % 2 == 0) ? 8'h00 : 8'((i % (2 * W)) / 2);
            checks++; if (bytes[i] !== eb) begin errors++; $display("FAIL ramp_byte[%0d]: got %h expected %h", i, bytes[i], eb); end
        end
        $display("test_ramp_frame done");
    endtask

    task automatic test_bars();
        int t, lat, j;
        logic [7:0] bytes[$];
        logic [12:0] got, exp;
        logic [15:0] bc;
        logic [7:0] eb;
        mode = 2'd2;
        enable = 1'b1;
        lat = 0;
        while (!vsync && lat < 4) begin tick(); lat++; end
        t = 0;
        while (busy && t < 2 * FS + 20) begin
            got = {pclk, vsync, href, busy, frame_done, d};
            exp = {m_ph, e_vsync(), e_href(), m_run, m_done, e_d()};
            checks++; if (got !== exp) begin errors++; $display("FAIL bars_cycle t=%0d: got %h expected %h", t, got, exp); end
            if (href && pclk) bytes.push_back(d);
            if (t == 10) enable = 1'b0;
            tick(); t++;
        end
        checks++; if (bytes.size() != 2 * W * H) begin errors++; $display("FAIL bars_byte_count: got %0d expected %0d", bytes.size(), 2 * W * H); end
        for (int i = 0; i < bytes.size() && i < 2 * W * H; i++) begin
            j  = i % (2 * W);
            bc = BARS_REF[(j / 2) / (W / 8)];
            eb = (j % 2 == 0) ? bc[15:8] : bc[7:0];
            checks++; if (bytes[i] !== eb) begin errors++; $display("FAIL bars_byte[%0d]: got %h expected %h", i, bytes[i], eb); end
        end
        $display("test_bars done");
    endtask

    task automatic test_back_to_back();
        int t, ndone, last_t, n;
        logic [12:0] got, exp;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mode = 2'($urandom_range(0, 3));
        fixed_pixel = 16'($urandom);
        enable = 1'b1;
        t = 0; ndone = 0; last_t = -1;
        while (ndone < 3 && t < 4 * 2 * FS) begin
            tick(); t++;
            got = {pclk, vsync, href, busy, frame_done, d};
            exp = {m_ph, e_vsync(), e_href(), m_run, m_done, e_d()};
            checks++; if (got !== exp) begin errors++; $display("FAIL b2b_cycle t=%0d: got %h expected %h", t, got, exp); end
            if (t % 37 == 0) begin
                mode = 2'($urandom_range(0, 3));
                fixed_pixel = 16'($urandom);
            end
            if (frame_done) begin
                ndone++;
                checks++; if (frame_cnt !== 16'(ndone)) begin errors++; $display("FAIL b2b_frame_cnt: got %0d expected %0d", frame_cnt, ndone); end
                if (last_t >= 0) begin
                    checks++; if (t - last_t != 2 * FS) begin errors++; $display("FAIL b2b_period: got %0d clk expected %0d", t - last_t, 2 * FS); end
                end
                last_t = t;
                tick(); t++;
                checks++; if ({frame_done, vsync} !== 2'b00) begin errors++; $display("FAIL b2b_after_done: {frame_done,vsync} got %b expected 00", {frame_done, vsync}); end
                tick(); t++;
                checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL b2b_vsync_restart: got %b expected 1", vsync); end
            end
        end
        checks++; if (ndone != 3) begin errors++; $display("FAIL b2b_done_count: got %0d expected 3", ndone); end
        enable = 1'b0;
        n = 0;
        while (busy && n < 2 * FS + 10) begin tick(); n++; end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy got %b expected 0", busy); end
        $display("test_back_to_back done");
    endtask

    task automatic test_enable_drop();
        int t, lat, ndone, busy_cnt;
        logic prev;
        logic [12:0] got, exp;
        mode = 2'd0;
        enable = 1'b1;
        lat = 0;
        while (!vsync && lat < 4) begin tick(); lat++; end
        t = 0; ndone = 0; busy_cnt = 0;
        while (busy && t < 2 * FS + 10) begin
            got = {pclk, vsync, href, busy, frame_done, d};
            exp = {m_ph, e_vsync(), e_href(), m_run, m_done, e_d()};
            checks++; if (got !== exp) begin errors++; $display("FAIL drop_cycle t=%0d: got %h expected %h", t, got, exp); end
            if (frame_done) ndone++;
            busy_cnt++;
            if (t == 50) begin
                enable = 1'b0;
                mode = 2'd3;
                fixed_pixel = 16'($urandom_range(16'h0100, 16'hFFFF));
            end
            tick(); t++;
        end
        checks++; if (ndone != 1) begin errors++; $display("FAIL drop_done_count: got %0d expected 1", ndone); end
        checks++; if (busy_cnt != 2 * FS) begin errors++; $display("FAIL drop_busy_len: got %0d expected %0d", busy_cnt, 2 * FS); end
        for (int i = 0; i < 6; i++) begin
            prev = pclk;
            tick();
            checks++; if ({busy, vsync, href, d} !== 11'h0) begin errors++; $display("FAIL drop_idle_outputs: got %h expected 000", {busy, vsync, href, d}); end
            checks++; if (pclk !== ~prev) begin errors++; $display("FAIL drop_pclk_toggle: got %b expected %b", pclk, ~prev); end
        end
        $display("test_enable_drop done");
    endtask

    task automatic test_reset_mid();
        int n, lat, want_lat;
        logic [12:0] got, exp;
        mode = 2'($urandom_range(0, 3));
        fixed_pixel = 16'($urandom);
        enable = 1'b1;
        n = 0;
        while (!(m_run && (m_k / L == VS + VB + 1) && (m_k % L == 5)) && n < 2 * FS + 10) begin tick(); n++; end
        checks++; if (href !== 1'b1) begin errors++; $display("FAIL rstmid_in_line: href got %b expected 1", href); end
        checks++; if (frame_cnt !== m_cnt) begin errors++; $display("FAIL rstmid_cnt_before: got %0d expected %0d", frame_cnt, m_cnt); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({pclk, vsync, href, busy, frame_done, d, frame_cnt} !== 29'h0) begin
            errors++; $display("FAIL rstmid_async: got %h expected 0", {pclk, vsync, href, busy, frame_done, d, frame_cnt});
        end
        repeat (2) tick();
        rst_n = 1'b1;
        want_lat = m_ph ? 1 : 2;
        lat = 0;
        while (!vsync && lat < 4) begin tick(); lat++; end
        checks++; if (lat != want_lat) begin errors++; $display("FAIL rstmid_restart_latency: got %0d expected %0d", lat, want_lat); end
        for (int i = 0; i < 120; i++) begin
            got = {pclk, vsync, href, busy, frame_done, d};
            exp = {m_ph, e_vsync(), e_href(), m_run, m_done, e_d()};
            checks++; if (got !== exp) begin errors++; $display("FAIL rstmid_cycle i=%0d: got %h expected %h", i, got, exp); end
            tick();
        end
        enable = 1'b0;
        n = 0;
        while (busy && n < 2 * FS + 10) begin tick(); n++; end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL rstmid_cnt_after: got %0d expected 1", frame_cnt); end
        $display("test_reset_mid done");
    endtask

    task automatic test_wrap();
        int n;
        force dut.frame_cnt_q = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        #1;
        checks++; if (frame_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h expected ffff", frame_cnt); end
        mode = 2'd1;
        enable = 1'b1;
        n = 0;
        while (!busy && n < 4) begin tick(); n++; end
        enable = 1'b0;
        n = 0;
        while (!frame_done && n < 2 * FS + 10) begin tick(); n++; end
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL wrap_done_seen: got %b expected 1", frame_done); end
        checks++; if (frame_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_frame_cnt: got %h expected 0000", frame_cnt); end
        repeat (4) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_idle: busy got %b expected 0", busy); end
        $display("test_wrap done");
    endtask

    initial begin
        test_reset();
        test_ramp_frame();
        test_bars();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
